// File: rtl/memresp_pkg.sv
// memresp_pkg
// Shared definitions for the memory responder slice:
//   - FSM state encoding (IDLE=0, WAIT=1, RESP=2)
//   - default parameter values for memory_responder
//   - width of the wait-state counter
package memresp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_WAIT_STATES = 2;

    // Wide enough for wait_states in the range 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/memresp_array.sv
// memresp_array
// Word storage for memory_responder: 2**addr_width words of data_width bits.
// Synchronous write and registered read, both gated by en_i. The read
// register holds its value until the next enabled read. Contents are not
// cleared by reset; only the read register is.
// Optional feature: MEMRESP_PARITY_EN adds one even-parity bit per word
// and a registered parity-error flag.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   en_i        access strobe (one cycle)
//   we_i        1 = write wdata_i, 0 = read into rdata_o
//   addr_i      word address
//   wdata_i     write data
//   rdata_o     registered read data
//   par_err_o   registered parity error (MEMRESP_PARITY_EN only)
module memresp_array #(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [addr_width-1:0] addr_i,
    input  logic [data_width-1:0] wdata_i,
`ifdef MEMRESP_PARITY_EN
    output logic                  par_err_o,
`endif
    output logic [data_width-1:0] rdata_o
);

    localparam int DEPTH = 1 << addr_width;

    logic [data_width-1:0] mem_q [DEPTH];
    logic [data_width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef MEMRESP_PARITY_EN
    logic par_mem_q [DEPTH];
    logic par_err_q;

    // Even parity: the stored bit makes the total count of ones even.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            par_mem_q[addr_i] <= ^wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (en_i && !we_i) begin
            par_err_q <= par_mem_q[addr_i] ^ (^mem_q[addr_i]);
        end
    end

    assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Single-outstanding memory responder with a fixed number of wait states.
// A request is accepted only in IDLE; it is captured, waits wait_states
// cycles in WAIT, then spends exactly one cycle in RESP with ready=1.
// Optional feature: MEMRESP_PARITY_EN enables per-word parity and par_err.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   addr          request word address
//   data_in       write data
//   req           request strobe (sampled only in IDLE)
//   we            1 = write, 0 = read (sampled with req)
//   data_out      read data, held until the next read response
//   ready         one-cycle response pulse
//   busy          request in flight (WAIT or RESP)
//   par_err       read parity error (MEMRESP_PARITY_EN only)
//   dbg_state_o   current FSM state, for checkers
//
// Handshake: req is a strobe, not a held valid. It is taken on any rising
// edge where state is IDLE and req=1; while busy=1 req is ignored and never
// queued. ready is a one-cycle completion pulse with no back-pressure;
// data_out (and par_err) are valid from the ready cycle onward.
module memory_responder
    import memresp_pkg::*;
#(
    parameter int addr_width  = DEF_ADDR_WIDTH,
    parameter int data_width  = DEF_DATA_WIDTH,
    parameter int wait_states = DEF_WAIT_STATES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] data_in,
    input  logic                  req,
    input  logic                  we,
    output logic [data_width-1:0] data_out,
    output logic                  ready,
    output logic                  busy,
`ifdef MEMRESP_PARITY_EN
    output logic                  par_err,
`endif
    output logic [1:0]            dbg_state_o
);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [addr_width-1:0] addr_q;
    logic [data_width-1:0] wdata_q;
    logic                  we_q;

    logic                  capture;
    logic                  commit;
    logic [addr_width-1:0] acc_addr;
    logic [data_width-1:0] acc_wdata;
    logic                  acc_we;

    assign capture = (state_q == ST_IDLE) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (wait_states == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(wait_states);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= addr;
                wdata_q <= data_in;
                we_q    <= we;
            end
        end
    end

    // With wait_states=0 the array access happens on the same edge as the
    // capture, so the live inputs are used instead of the capture registers.
    assign acc_addr  = capture ? addr    : addr_q;
    assign acc_wdata = capture ? data_in : wdata_q;
    assign acc_we    = capture ? we      : we_q;

    // The array is touched only on the edge entering RESP, so a reset during
    // WAIT drops a pending write without committing it.
    memresp_array #(
        .addr_width (addr_width),
        .data_width (data_width)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .en_i      (commit),
        .we_i      (acc_we),
        .addr_i    (acc_addr),
        .wdata_i   (acc_wdata),
`ifdef MEMRESP_PARITY_EN
        .par_err_o (par_err),
`endif
        .rdata_o   (data_out)
    );

    assign ready       = (state_q == ST_RESP);
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Directed bench for memory_responder. Two instances share clk/rst:
// dut (wait_states=2) and dut0 (wait_states=0).
// Parity scenario is compiled only with MEMRESP_PARITY_EN.
module tb_memory_responder;

    logic clk;
    logic rst;

    logic [7:0] addr2, din2, dout2;
    logic       req2, we2, rdy2, busy2;
    logic [1:0] st2;
    logic [7:0] addr0, din0, dout0;
    logic       req0, we0, rdy0, busy0;
    logic [1:0] st0;
`ifdef MEMRESP_PARITY_EN
    logic       perr2, perr0;
`endif

    int n_tests;
    int n_fail;

    memory_responder #(.addr_width(8), .data_width(8), .wait_states(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr2),
        .data_in     (din2),
        .req         (req2),
        .we          (we2),
        .data_out    (dout2),
        .ready       (rdy2),
        .busy        (busy2),
`ifdef MEMRESP_PARITY_EN
        .par_err     (perr2),
`endif
        .dbg_state_o (st2)
    );

    memory_responder #(.addr_width(8), .data_width(8), .wait_states(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr0),
        .data_in     (din0),
        .req         (req0),
        .we          (we0),
        .data_out    (dout0),
        .ready       (rdy0),
        .busy        (busy0),
`ifdef MEMRESP_PARITY_EN
        .par_err     (perr0),
`endif
        .dbg_state_o (st0)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int inst, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (inst == 0) begin
            req0 = r; we0 = w; addr0 = a; din0 = d;
        end else begin
            req2 = r; we2 = w; addr2 = a; din2 = d;
        end
    endtask

    function automatic logic rdy_of(input int inst);
        return (inst == 0) ? rdy0 : rdy2;
    endfunction

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy0 : busy2;
    endfunction

    // One request: req pulsed for a single edge. lat = edges from the
    // sampling edge (counted as 1) up to the ready cycle, -1 on timeout.
    // bcnt = busy-high samples up to and including the ready cycle.
    task automatic txn(input int inst, input logic w, input logic [7:0] a,
                       input logic [7:0] d, output int lat, output int bcnt);
        bit got;
        got  = 1'b0;
        lat  = -1;
        bcnt = 0;
        drive(inst, 1'b1, w, a, d);
        for (int i = 1; i <= 12 && !got; i++) begin
            cyc();
            if (i == 1) drive(inst, 1'b0, 1'b0, a, d);
            if (busy_of(inst)) bcnt++;
            if (rdy_of(inst)) begin
                lat = i;
                got = 1'b1;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc();
        cyc();
        n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", rdy2); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy2); end
        n_tests++; if (dout2 !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout2); end
        n_tests++; if (st2 !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", st2); end
        n_tests++; if (dout0 !== 8'h00 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut0 got dout=%h rdy=%b busy=%b exp 00/0/0", dout0, rdy0, busy0);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        int lat, bcnt;
        txn(2, 1'b1, 8'h10, 8'hA5, lat, bcnt);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL write_latency got %0d exp 3", lat); end
        n_tests++; if (bcnt != 3) begin n_fail++; $display("FAIL write_busy_cycles got %0d exp 3", bcnt); end
        n_tests++; if (dout2 !== 8'h00) begin n_fail++; $display("FAIL write_dout_unchanged got %h exp 00", dout2); end
        cyc();
        n_tests++; if (rdy2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL write_idle_after got rdy=%b busy=%b exp 0/0", rdy2, busy2);
        end
    endtask

    task automatic test_read();
        int lat, bcnt;
        txn(2, 1'b0, 8'h10, 8'h00, lat, bcnt);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL read_latency got %0d exp 3", lat); end
        n_tests++; if (dout2 !== 8'hA5) begin n_fail++; $display("FAIL read_data got %h exp a5", dout2); end
        cyc();
        cyc();
        n_tests++; if (dout2 !== 8'hA5 || rdy2 !== 1'b0) begin
            n_fail++; $display("FAIL read_hold got dout=%h rdy=%b exp a5/0", dout2, rdy2);
        end
    endtask

    task automatic test_zero_wait();
        int lat, bcnt;
        txn(0, 1'b1, 8'hFF, 8'h3C, lat, bcnt);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL zw_write_latency got %0d exp 1", lat); end
        n_tests++; if (bcnt != 1) begin n_fail++; $display("FAIL zw_write_busy got %0d exp 1", bcnt); end
        cyc();
        txn(0, 1'b0, 8'hFF, 8'h00, lat, bcnt);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL zw_read_latency got %0d exp 1", lat); end
        n_tests++; if (dout0 !== 8'h3C) begin n_fail++; $display("FAIL zw_read_data got %h exp 3c", dout0); end
        cyc();
    endtask

    // req held high: ready every wait_states+2 cycles.
    task automatic test_back_to_back();
        logic exp_r;
        drive(0, 1'b1, 1'b0, 8'hFF, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp_r = (i % 2) == 1;
            n_tests++; if (rdy0 !== exp_r) begin
                n_fail++; $display("FAIL b2b_ws0 cycle %0d got %b exp %b", i, rdy0, exp_r);
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc();
        drive(2, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp_r = (i % 4) == 3;
            n_tests++; if (rdy2 !== exp_r) begin
                n_fail++; $display("FAIL b2b_ws2 cycle %0d got %b exp %b", i, rdy2, exp_r);
            end
        end
        drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc();
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_ws2_idle got busy=%b exp 0", busy2); end
    endtask

    task automatic test_busy_ignore();
        int lat, bcnt;
        txn(2, 1'b1, 8'h21, 8'h99, lat, bcnt);
        cyc();
        drive(2, 1'b1, 1'b1, 8'h20, 8'h11);
        cyc();
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b exp 1", busy2); end
        drive(2, 1'b1, 1'b1, 8'h21, 8'hEE);
        cyc();
        n_tests++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL ign_early_ready got %b exp 0", rdy2); end
        drive(2, 1'b0, 1'b0, 8'h22, 8'h44);
        cyc();
        n_tests++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL ign_ready got %b exp 1", rdy2); end
        cyc();
        cyc();
        n_tests++; if (rdy2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL ign_no_second got rdy=%b busy=%b exp 0/0", rdy2, busy2);
        end
        txn(2, 1'b0, 8'h20, 8'h00, lat, bcnt);
        n_tests++; if (dout2 !== 8'h11) begin n_fail++; $display("FAIL ign_addr20 got %h exp 11", dout2); end
        cyc();
        txn(2, 1'b0, 8'h21, 8'h00, lat, bcnt);
        n_tests++; if (dout2 !== 8'h99) begin n_fail++; $display("FAIL ign_addr21 got %h exp 99", dout2); end
        cyc();
        txn(2, 1'b0, 8'h22, 8'h00, lat, bcnt);
        n_tests++; if (dout2 === 8'h44) begin n_fail++; $display("FAIL ign_addr22 got %h exp not 44", dout2); end
        cyc();
    endtask

    task automatic test_reset_abort();
        int lat, bcnt;
        txn(2, 1'b1, 8'h30, 8'h55, lat, bcnt);
        cyc();
        txn(2, 1'b0, 8'h30, 8'h00, lat, bcnt);
        n_tests++; if (dout2 !== 8'h55) begin n_fail++; $display("FAIL abort_prior got %h exp 55", dout2); end
        cyc();
        drive(2, 1'b1, 1'b1, 8'h30, 8'h77);
        cyc();
        drive(2, 1'b0, 1'b0, 8'h30, 8'h00);
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL abort_in_wait got busy=%b exp 1", busy2); end
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (busy2 !== 1'b0 || rdy2 !== 1'b0 || dout2 !== 8'h00) begin
            n_fail++; $display("FAIL abort_async_clear got busy=%b rdy=%b dout=%h exp 0/0/00", busy2, rdy2, dout2);
        end
        cyc();
        rst = 1'b1;
        cyc();
        txn(2, 1'b0, 8'h30, 8'h00, lat, bcnt);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL abort_read_latency got %0d exp 3", lat); end
        n_tests++; if (dout2 !== 8'h55) begin n_fail++; $display("FAIL abort_not_committed got %h exp 55", dout2); end
        cyc();
    endtask

`ifdef MEMRESP_PARITY_EN
    task automatic test_parity();
        int lat, bcnt;
        txn(2, 1'b1, 8'h40, 8'h0F, lat, bcnt);
        cyc();
        txn(2, 1'b0, 8'h40, 8'h00, lat, bcnt);
        n_tests++; if (perr2 !== 1'b0 || dout2 !== 8'h0F) begin
            n_fail++; $display("FAIL par_clean got perr=%b dout=%h exp 0/0f", perr2, dout2);
        end
        cyc();
        dut.u_array.mem_q[8'h40] = dut.u_array.mem_q[8'h40] ^ 8'h01;
        txn(2, 1'b0, 8'h40, 8'h00, lat, bcnt);
        n_tests++; if (perr2 !== 1'b1 || rdy2 !== 1'b1) begin
            n_fail++; $display("FAIL par_flip got perr=%b rdy=%b exp 1/1", perr2, rdy2);
        end
        cyc();
        n_tests++; if (perr2 !== 1'b1) begin n_fail++; $display("FAIL par_hold got %b exp 1", perr2); end
        txn(2, 1'b0, 8'h10, 8'h00, lat, bcnt);
        n_tests++; if (perr2 !== 1'b0 || dout2 !== 8'hA5) begin
            n_fail++; $display("FAIL par_clean2 got perr=%b dout=%h exp 0/a5", perr2, dout2);
        end
        cyc();
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write();
        test_read();
        test_zero_wait();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
`ifdef MEMRESP_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
